eval_table_loader: RTL
======================

EVAL_TABLE_LOADER -- requirements
Module: eval_table_loader

Interface
REQ-001 SHALL have parameter REGEX_ADDR_W, default 14, regex table address width.
REQ-002 SHALL have parameter REGEX_DATA_W, default 15, regex table entry width.
REQ-003 SHALL have parameter FW_ADDR_W, default 19, firewall table address width.
REQ-004 SHALL have parameter FW_DATA_W, default 64, firewall table entry width.
REQ-005 SHALL have parameter CNT_W, default 8, burst count width.
REQ-006 SHALL have port axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port axi_aresetn  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports cmd_valid in 1 / cmd_ready out 1  command handshake.
REQ-009 SHALL have port cmd_target  in  1  0 = regex table, 1 = firewall table.
REQ-010 SHALL have port cmd_addr  in  FW_ADDR_W  start address; regex uses low REGEX_ADDR_W bits.
REQ-011 SHALL have port cmd_data  in  FW_DATA_W  entry data; regex uses low REGEX_DATA_W bits.
REQ-012 SHALL have port cmd_count  in  CNT_W  entries to write, same data, consecutive addresses; 0 treated as 1.
REQ-013 SHALL have port lookup_idle  in  1  high when no packet is using the tables.
REQ-014 SHALL have ports regex_we out 1, regex_addr out REGEX_ADDR_W, regex_din out REGEX_DATA_W.
REQ-015 SHALL have ports fw_we out 1, fw_addr out FW_ADDR_W, fw_din out FW_DATA_W.
REQ-016 SHALL have ports busy out 1, done out 1 (pulse), done_cnt out 16, err out 1 (sticky), err_clr in 1.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, WRITE, DONE.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready.
REQ-019 On acceptance, SHALL latch target, addr, data, count (0 -> 1) into internal registers.
REQ-020 On acceptance, if addr + count - 1 exceeds the target table's max address (2^REGEX_ADDR_W-1 or 2^FW_ADDR_W-1), SHALL set err, perform no writes, and remain in IDLE.
REQ-021 Otherwise IDLE SHALL go to WAIT on the cycle after acceptance.
REQ-022 WAIT SHALL go to WRITE when lookup_idle = 1, and hold otherwise.
REQ-023 In WRITE, the selected table's we SHALL be high for exactly one cycle per entry, with registered addr/din; the other table's we SHALL stay 0.
REQ-024 After each write, the address SHALL increment by 1 and the remaining count SHALL decrement by 1.
REQ-025 From WRITE: remaining = 0 -> DONE; else lookup_idle = 0 -> WAIT; else stay in WRITE (back-to-back writes).
REQ-026 lookup_idle falling SHALL never interrupt an already-issued write; the pause takes effect from the next entry.
REQ-027 DONE SHALL pulse done for 1 cycle, increment done_cnt (wraps 65535 -> 0), then return to IDLE.
REQ-028 busy SHALL be 1 in WAIT, WRITE and DONE, and 0 in IDLE.
REQ-029 err SHALL clear on err_clr; a simultaneous set and clear SHALL leave err = 1.
REQ-030 Latency: acceptance in cycle T with lookup_idle held at 1 -> first we in T+2; N entries -> done in T+N+2.
REQ-031 When a we is low, its addr/din outputs SHALL hold their last value.

Reset
REQ-032 Reset assertion SHALL asynchronously force: state IDLE, cmd_ready 1, all we 0, all addr/din 0, busy 0, done 0, done_cnt 0, err 0.
REQ-033 Reset during WAIT or WRITE SHALL discard the in-flight command with no further writes; after release, the block SHALL accept a new command.

Verification
REQ-034 Regex single: target 0, addr 0x10, data 0x1ABC, count 1, lookup_idle = 1 -> regex_we at T+2 with addr 0x10, din 0x1ABC; done at T+3; done_cnt = 1.
REQ-035 Firewall burst: target 1, addr 0x7FFFD, count 3 -> fw_we on 3 consecutive cycles at addrs 0x7FFFD, 0x7FFFE, 0x7FFFF; regex_we stays 0.
REQ-036 Range error: target 0, addr 0x3FFF, count 2 -> no we, err = 1, busy stays 0; err_clr pulse -> err = 0.
REQ-037 Stall: count 4, lookup_idle dropped after the 2nd write for 5 cycles -> exactly 2 writes, a pause, then 2 writes after lookup_idle returns; single done pulse.
REQ-038 Reset mid-burst: count 10, axi_aresetn low after the 3rd write -> we = 0 immediately, done_cnt = 0; a new command completes normally.

Source files
------------

// File: rtl/eval_table_loader.sv
// Loads burst writes into the regex and firewall lookup tables. Each command
// writes one data word to consecutive addresses, and it only writes while the lookup path is idle.
module eval_table_loader #(
  parameter int REGEX_ADDR_W = 14,
  parameter int REGEX_DATA_W = 15,
  parameter int FW_ADDR_W    = 19,
  parameter int FW_DATA_W    = 64,
  parameter int CNT_W        = 8
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_target,
  input  logic [FW_ADDR_W-1:0]    cmd_addr,
  input  logic [FW_DATA_W-1:0]    cmd_data,
  input  logic [CNT_W-1:0]        cmd_count,
  input  logic                    lookup_idle,
  output logic                    regex_we,
  output logic [REGEX_ADDR_W-1:0] regex_addr,
  output logic [REGEX_DATA_W-1:0] regex_din,
  output logic                    fw_we,
  output logic [FW_ADDR_W-1:0]    fw_addr,
  output logic [FW_DATA_W-1:0]    fw_din,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             done_cnt,
  output logic                    err,
  input  logic                    err_clr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_DONE} state_e;

  // The width must hold the last address of the largest possible burst without overflowing.
  localparam int END_W = FW_ADDR_W + CNT_W + 1;

  state_e                  state_q, state_d;
  logic                    target_q;
  logic [FW_ADDR_W-1:0]    addr_q;
  logic [FW_DATA_W-1:0]    data_q;
  logic [CNT_W-1:0]        rem_q;
  logic [REGEX_ADDR_W-1:0] regex_addr_q;
  logic [REGEX_DATA_W-1:0] regex_din_q;
  logic [FW_ADDR_W-1:0]    fw_addr_q;
  logic [FW_DATA_W-1:0]    fw_din_q;
  logic [15:0]             done_cnt_q;
  logic                    err_q;

  logic             accept;
  logic             range_err;
  logic             issue;
  logic [CNT_W-1:0] cnt_eff;
  logic [END_W-1:0] last_rx;
  logic [END_W-1:0] last_fw;

  assign accept  = cmd_valid && (state_q == S_IDLE);
  assign cnt_eff = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
  assign last_rx = END_W'(cmd_addr[REGEX_ADDR_W-1:0]) + END_W'(cnt_eff) - END_W'(1);
  assign last_fw = END_W'(cmd_addr) + END_W'(cnt_eff) - END_W'(1);
  assign range_err = cmd_target ? (|last_fw[END_W-1:FW_ADDR_W])
                                : (|last_rx[END_W-1:REGEX_ADDR_W]);

  // A write is issued on every edge that lands the FSM in WRITE.
  assign issue = (state_d == S_WRITE);

  // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    // NOTE: a default first keeps every path assigned, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept && !range_err) state_d = S_WAIT;
      S_WAIT:  if (lookup_idle) state_d = S_WRITE;
      S_WRITE: begin
        if (rem_q == '0)      state_d = S_DONE;
        else if (!lookup_idle) state_d = S_WAIT;
        else                   state_d = S_WRITE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    regex_we  = (state_q == S_WRITE) && !target_q;
    fw_we     = (state_q == S_WRITE) && target_q;
  end

  // rem_q counts the entries that have not been issued yet.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      target_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      rem_q        <= '0;
      regex_addr_q <= '0;
      regex_din_q  <= '0;
      fw_addr_q    <= '0;
      fw_din_q     <= '0;
    end else if (accept && !range_err) begin
      target_q <= cmd_target;
      addr_q   <= cmd_addr;
      data_q   <= cmd_data;
      rem_q    <= cnt_eff;
    end else if (issue) begin
      addr_q <= addr_q + FW_ADDR_W'(1);
      rem_q  <= rem_q - CNT_W'(1);
      if (target_q) begin
        fw_addr_q <= addr_q;
        fw_din_q  <= data_q;
      end else begin
        regex_addr_q <= addr_q[REGEX_ADDR_W-1:0];
        regex_din_q  <= data_q[REGEX_DATA_W-1:0];
      end
    end
  end

  // If err is set and cleared in the same cycle, the set wins.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      err_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      if (accept && range_err) err_q <= 1'b1;
      else if (err_clr)        err_q <= 1'b0;
      if (state_q == S_DONE) done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

  assign regex_addr = regex_addr_q;
  assign regex_din  = regex_din_q;
  assign fw_addr    = fw_addr_q;
  assign fw_din     = fw_din_q;
  assign done_cnt   = done_cnt_q;
  assign err        = err_q;

endmodule
